// File: rtl/keypad_time_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_time_entry_if
// Description : Keypad / timer-chain signal bundle for keypad_time_entry.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_time_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       timer_zero;
  logic       load;
  logic       stop;
  logic       timer_clear;
  logic [3:0] bcd_min_t;
  logic [3:0] bcd_min_u;
  logic [3:0] bcd_sec_t;
  logic [3:0] bcd_sec_u;
  logic       running;
  logic       done;
  logic       error;

  modport master (
    output key_valid, key_code, timer_zero,
    input  load, stop, timer_clear, bcd_min_t, bcd_min_u, bcd_sec_t, bcd_sec_u,
    input  running, done, error
  );

  modport slave (
    input  key_valid, key_code, timer_zero,
    output load, stop, timer_clear, bcd_min_t, bcd_min_u, bcd_sec_t, bcd_sec_u,
    output running, done, error
  );
endinterface
`default_nettype wire

// File: rtl/keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module      : keypad_time_entry
// Description : Microwave timer front end: MM:SS keypad entry, validation and
//               run/pause/cancel/done supervision. Optional macro QUICK_START_EN
//               enables a 30 s quick start from IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_time_entry #(
  parameter int DONE_CYCLES = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  keypad_time_entry_if.slave  bus
);

  localparam int         C_DCNT_W    = $clog2(DONE_CYCLES + 1);
  localparam logic [3:0] C_KEY_START = 4'd10;
  localparam logic [3:0] C_KEY_CANCEL = 4'd11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         buf_q, buf_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [C_DCNT_W-1:0] dcnt_q, dcnt_d;
  logic                load_q, load_d;
  logic                clear_q, clear_d;
  logic                stop_q, stop_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic w_digit, w_start, w_cancel, w_buf_ok;

  assign w_digit  = bus.key_valid && (bus.key_code <= 4'd9);
  assign w_start  = bus.key_valid && (bus.key_code == C_KEY_START);
  assign w_cancel = bus.key_valid && (bus.key_code == C_KEY_CANCEL);
  assign w_buf_ok = (buf_q != 16'h0000) && (buf_q[7:4] <= 4'd5);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    error_d = 1'b0;
    clear_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_digit) begin
          buf_d   = {buf_q[11:0], bus.key_code};
          cnt_d   = cnt_q + 3'd1;
          state_d = ENTRY;
        end
`ifdef QUICK_START_EN
        else if (w_start) begin
          buf_d   = 16'h0030;
          cnt_d   = 3'd2;
          state_d = LOAD;
        end
`endif
      end
      ENTRY: begin
        if (w_digit && (cnt_q < 3'd4)) begin
          buf_d = {buf_q[11:0], bus.key_code};
          cnt_d = cnt_q + 3'd1;
        end else if (w_start) begin
          if (w_buf_ok) state_d = LOAD;
          else          error_d = 1'b1;
        end else if (w_cancel) begin
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Zero flag outranks a simultaneous CANCEL
        if (bus.timer_zero) begin
          state_d = DONE;
          dcnt_d  = C_DCNT_W'(DONE_CYCLES);
        end else if (w_cancel) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (w_start) begin
          state_d = RUN;
        end else if (w_cancel) begin
          clear_d = 1'b1;
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (w_cancel || (dcnt_q <= C_DCNT_W'(1))) begin
          buf_d   = 16'h0000;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q - C_DCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    load_d    = (state_d == LOAD);
    stop_d    = (state_d != RUN);
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      buf_q     <= 16'h0000;
      cnt_q     <= 3'd0;
      dcnt_q    <= '0;
      load_q    <= 1'b0;
      clear_q   <= 1'b0;
      stop_q    <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      load_q    <= load_d;
      clear_q   <= clear_d;
      stop_q    <= stop_d;
      running_q <= running_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign bus.load        = load_q;
  assign bus.stop        = stop_q;
  assign bus.timer_clear = clear_q;
  assign bus.bcd_min_t   = buf_q[15:12];
  assign bus.bcd_min_u   = buf_q[11:8];
  assign bus.bcd_sec_t   = buf_q[7:4];
  assign bus.bcd_sec_u   = buf_q[3:0];
  assign bus.running     = running_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_time_entry
// Description : Directed self-checking bench for keypad_time_entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_time_entry;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  keypad_time_entry_if bus ();

  keypad_time_entry #(.DONE_CYCLES(8)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bcd_word();
    return {bus.bcd_min_t, bus.bcd_min_u, bus.bcd_sec_t, bus.bcd_sec_u};
  endfunction

  task automatic press(input logic [3:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({bus.load, bus.stop, bus.timer_clear, bus.running, bus.done, bus.error} !== 6'b010000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b exp=010000",
               {bus.load, bus.stop, bus.timer_clear, bus.running, bus.done, bus.error});
    end
    tests_run++;
    if (bcd_word() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_buf got=%h exp=0000", bcd_word());
    end
  endtask

  task automatic test_entry_run();
    int n;
    press(4'd1); press(4'd3); press(4'd0);
    tests_run++;
    if (bcd_word() !== 16'h0130) begin
      tests_failed++;
      $display("FAIL entry_buf got=%h exp=0130", bcd_word());
    end
    press(4'd10);
    tests_run++;
    if ({bus.load, bus.running, bus.stop} !== 3'b101) begin
      tests_failed++;
      $display("FAIL load_cycle got=%b exp=101", {bus.load, bus.running, bus.stop});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.load, bus.running, bus.stop} !== 3'b010) begin
      tests_failed++;
      $display("FAIL run_cycle got=%b exp=010", {bus.load, bus.running, bus.stop});
    end
    press(4'd7);
    tests_run++;
    if (bcd_word() !== 16'h0130) begin
      tests_failed++;
      $display("FAIL run_digit_ignored got=%h exp=0130", bcd_word());
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_early_done got=%b exp=0", bus.done);
    end
    bus.timer_zero = 1'b1;
    @(negedge clk);
    bus.timer_zero = 1'b0;
    tests_run++;
    if ({bus.done, bus.stop, bus.running} !== 3'b110) begin
      tests_failed++;
      $display("FAIL done_entry got=%b exp=110", {bus.done, bus.stop, bus.running});
    end
    n = 0;
    while (bus.done === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (n !== 8) begin
      tests_failed++;
      $display("FAIL done_length got=%0d exp=8", n);
    end
    tests_run++;
    if (bcd_word() !== 16'h0000 || bus.stop !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_exit got buf=%h stop=%b exp buf=0000 stop=1", bcd_word(), bus.stop);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) press(4'(i));
    tests_run++;
    if (bcd_word() !== 16'h1234) begin
      tests_failed++;
      $display("FAIL overflow_buf got=%h exp=1234", bcd_word());
    end
    press(4'd13);
    tests_run++;
    if (bcd_word() !== 16'h1234 || bus.error !== 1'b0) begin
      tests_failed++;
      $display("FAIL code13_ignored got buf=%h err=%b exp 1234/0", bcd_word(), bus.error);
    end
    press(4'd11);
    tests_run++;
    if (bcd_word() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL entry_cancel got=%h exp=0000", bcd_word());
    end
  endtask

  task automatic test_reject();
    press(4'd0); press(4'd9); press(4'd0);
    press(4'd10);
    tests_run++;
    if ({bus.error, bus.load} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reject_pulse got=%b exp=10", {bus.error, bus.load});
    end
    @(negedge clk);
    tests_run++;
    if (bus.error !== 1'b0 || bcd_word() !== 16'h0090 || bus.load !== 1'b0) begin
      tests_failed++;
      $display("FAIL reject_after got err=%b buf=%h load=%b exp 0/0090/0",
               bus.error, bcd_word(), bus.load);
    end
    press(4'd1);
    tests_run++;
    if (bcd_word() !== 16'h0901) begin
      tests_failed++;
      $display("FAIL still_entry got=%h exp=0901", bcd_word());
    end
    press(4'd11);
    press(4'd0);
    press(4'd10);
    tests_run++;
    if ({bus.error, bus.load} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reject_zero got=%b exp=10", {bus.error, bus.load});
    end
    press(4'd11);
  endtask

  task automatic test_pause();
    press(4'd2); press(4'd10);
    @(negedge clk);
    press(4'd11);
    tests_run++;
    if ({bus.stop, bus.running} !== 2'b10) begin
      tests_failed++;
      $display("FAIL pause got=%b exp=10", {bus.stop, bus.running});
    end
    press(4'd10);
    tests_run++;
    if ({bus.stop, bus.running, bus.load} !== 3'b010) begin
      tests_failed++;
      $display("FAIL resume got=%b exp=010", {bus.stop, bus.running, bus.load});
    end
    press(4'd11);
    press(4'd11);
    tests_run++;
    if (bus.timer_clear !== 1'b1 || bcd_word() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL pause_cancel got clr=%b buf=%h exp 1/0000", bus.timer_clear, bcd_word());
    end
    @(negedge clk);
    tests_run++;
    if (bus.timer_clear !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_width got=%b exp=0", bus.timer_clear);
    end
  endtask

  task automatic test_zero_cancel();
    press(4'd5); press(4'd10);
    @(negedge clk);
    bus.key_valid  = 1'b1;
    bus.key_code   = 4'd11;
    bus.timer_zero = 1'b1;
    @(negedge clk);
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'd0;
    bus.timer_zero = 1'b0;
    tests_run++;
    if ({bus.done, bus.stop, bus.running} !== 3'b110) begin
      tests_failed++;
      $display("FAIL zero_beats_cancel got=%b exp=110", {bus.done, bus.stop, bus.running});
    end
    press(4'd11);
    tests_run++;
    if (bus.done !== 1'b0 || bcd_word() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL done_cancel got done=%b buf=%h exp 0/0000", bus.done, bcd_word());
    end
  endtask

  task automatic test_async_reset();
    press(4'd4); press(4'd5); press(4'd10);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.stop, bus.running, bus.load, bus.done} !== 4'b1000 || bcd_word() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL async_reset got flags=%b buf=%h exp 1000/0000",
               {bus.stop, bus.running, bus.load, bus.done}, bcd_word());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_quick_start();
    press(4'd10);
`ifdef QUICK_START_EN
    tests_run++;
    if (bus.load !== 1'b1 || bcd_word() !== 16'h0030) begin
      tests_failed++;
      $display("FAIL quick_start got load=%b buf=%h exp 1/0030", bus.load, bcd_word());
    end
`else
    tests_run++;
    if ({bus.load, bus.error, bus.running} !== 3'b000 || bcd_word() !== 16'h0000) begin
      tests_failed++;
      $display("FAIL idle_start got flags=%b buf=%h exp 000/0000",
               {bus.load, bus.error, bus.running}, bcd_word());
    end
    @(negedge clk);
    tests_run++;
    if (bus.running !== 1'b0 || bus.stop !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_start_run got run=%b stop=%b exp 0/1", bus.running, bus.stop);
    end
`endif
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'd0;
    bus.timer_zero = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_entry_run();
    test_overflow();
    test_reject();
    test_pause();
    test_zero_cancel();
    test_async_reset();
    test_reset();
    test_quick_start();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
